// File: rtl/regfile_mport_pkg.sv
// Shared types for the multi-port GPR file: word/address types,
// write-lane and claim-lane bundles, and an address-match helper.
package regfile_mport_pkg;

  localparam int XLEN     = 32;
  localparam int NREG_DEF = 32;
  localparam int CREG_W   = $clog2(NREG_DEF);

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [CREG_W-1:0] creg_addr_t;

  typedef struct packed {
    logic       wen;
    creg_addr_t addr;
    word_t      wd;
  } rf_w_t;

  typedef struct packed {
    logic       en;
    creg_addr_t addr;
  } rf_claim_t;

  // r0 never matches anything: it has no state and no producer.
  function automatic logic addr_hit(
    input creg_addr_t a,
    input creg_addr_t b
  );
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/regfile_mport_scoreboard.sv
// Per-register busy scoreboard: flush > claim > write-clear > hold.
// Ports: clk, reset, wr lanes (clear), claim lanes, flush, ra in, rbusy out.
module regfile_mport_scoreboard
  import regfile_mport_pkg::*;
#(
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int NREG   = NREG_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  rf_w_t     [NWRITE-1:0]       wr,
  input  rf_claim_t [NWRITE-1:0]       claim,
  input  logic                         flush,
  input  creg_addr_t [NREAD-1:0]       ra,
  output logic      [NREAD-1:0]        rbusy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clears applied first, then claims, then flush: later assignment
  // wins, giving the required priority order.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWRITE; w++)
      if (wr[w].wen)
        busy_d[wr[w].addr] = 1'b0;
    for (int c = 0; c < NWRITE; c++)
      if (claim[c].en)
        busy_d[claim[c].addr] = 1'b1;
    if (flush)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  always_comb begin
    for (int p = 0; p < NREAD; p++)
      rbusy[p] = busy_q[ra[p]];
  end

endmodule

// File: rtl/regfile_mport.sv
// Multi-port GPR file: NREAD async reads, NWRITE sync writes, busy scoreboard.
// Ports: clk, reset, ra/rd/rbusy, wen/waddr/wdata, claim_en/claim_addr, flush.
// Option: REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mport
  import regfile_mport_pkg::*;
#(
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int DATA_W = XLEN,
  parameter int NREG   = NREG_DEF,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREAD*ADDR_W-1:0]  ra,
  output logic [NREAD*DATA_W-1:0]  rd,
  output logic [NREAD-1:0]         rbusy,
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NWRITE-1:0]        claim_en,
  input  logic [NWRITE*ADDR_W-1:0] claim_addr,
  input  logic                     flush
);

  rf_w_t      [NWRITE-1:0] wr;
  rf_claim_t  [NWRITE-1:0] cl;
  creg_addr_t [NREAD-1:0]  ra_v;
  word_t                   rd_v [NREAD];
  logic       [NREAD-1:0]  rb_v;
  logic       [NREAD-1:0]  sb_busy;
  word_t                   regs [NREG];

  for (genvar w = 0; w < NWRITE; w++) begin : g_lane
    assign wr[w].wen  = wen[w];
    assign wr[w].addr = waddr[w*ADDR_W +: ADDR_W];
    assign wr[w].wd   = wdata[w*DATA_W +: DATA_W];
    assign cl[w].en   = claim_en[w];
    assign cl[w].addr = claim_addr[w*ADDR_W +: ADDR_W];
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    assign ra_v[p]                = ra[p*ADDR_W +: ADDR_W];
    assign rd[p*DATA_W +: DATA_W] = rd_v[p];
    assign rbusy[p]               = rb_v[p];
  end

  regfile_mport_scoreboard #(
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .NREG   (NREG)
  ) u_sb (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .claim (cl),
    .flush (flush),
    .ra    (ra_v),
    .rbusy (sb_busy)
  );

  // Lanes in ascending order: the younger (higher) lane's NBA lands last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
    end else begin
      for (int w = 0; w < NWRITE; w++)
        if (wr[w].wen && wr[w].addr != '0)
          regs[wr[w].addr] <= wr[w].wd;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [NREAD-1:0] chit;

  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      chit[p] = 1'b0;
      for (int c = 0; c < NWRITE; c++)
        if (cl[c].en && addr_hit(ra_v[p], cl[c].addr))
          chit[p] = 1'b1;
    end
  end
`endif

  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      rd_v[p] = regs[ra_v[p]];
      rb_v[p] = sb_busy[p];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWRITE; w++)
        if (wr[w].wen && addr_hit(ra_v[p], wr[w].addr)) begin
          rd_v[p] = wr[w].wd;
          rb_v[p] = chit[p] && !flush;
        end
`endif
      if (ra_v[p] == '0) begin
        rd_v[p] = '0;
        rb_v[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mport.sv
// Directed self-checking bench for regfile_mport.
// Covers reset, lane conflicts, r0, scoreboard priority, flush, bypass.
module tb_regfile_mport;

  localparam int NR = 4;
  localparam int NW = 2;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk;
  logic              reset;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rbusy;
  logic [NW-1:0]     wen;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic [NW-1:0]     claim_en;
  logic [NW*AW-1:0]  claim_addr;
  logic              flush;

  int checks;
  int failures;

  regfile_mport #(
    .NREAD  (NR),
    .NWRITE (NW),
    .DATA_W (DW),
    .NREG   (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ra         (ra),
    .rd         (rd),
    .rbusy      (rbusy),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wen        = '0;
    waddr      = '0;
    wdata      = '0;
    claim_en   = '0;
    claim_addr = '0;
    flush      = 1'b0;
  endtask

  task automatic set_w(input int l, input logic [4:0] a,
                       input logic [31:0] d);
    wen[l]            = 1'b1;
    waddr[l*AW +: AW] = a;
    wdata[l*DW +: DW] = d;
  endtask

  task automatic set_c(input int l, input logic [4:0] a);
    claim_en[l]            = 1'b1;
    claim_addr[l*AW +: AW] = a;
  endtask

  task automatic set_ra(input int p, input logic [4:0] a);
    ra[p*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rdp(input int p);
    return rd[p*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ra       = '0;
    idle();
    set_ra(0, 5'd5);
    set_ra(1, 5'd31);
    #2;
    chk("rst_rd5", rdp(0), 32'h0);
    chk("rst_rd31", rdp(1), 32'h0);
    chk("rst_busy", {28'h0, rbusy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // reset mid-operation
    @(posedge clk); #1;
    set_w(0, 5'd5, 32'hDEADBEEF);
    set_c(0, 5'd5);
    tick();
    #1;
    chk("pre_rd5", rdp(0), 32'hDEADBEEF);
    chk("pre_busy5", {31'h0, rbusy[0]}, 32'h1);
    set_w(1, 5'd6, 32'h66);
    set_c(1, 5'd6);
    set_ra(1, 5'd6);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_rd5", rdp(0), 32'h0);
    chk("midrst_busy", {28'h0, rbusy}, 32'h0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_drop_rd6", rdp(1), 32'h0);
    chk("rst_drop_b6", {31'h0, rbusy[1]}, 32'h0);

    // dual write to same address
    @(posedge clk); #1;
    set_w(0, 5'd7, 32'h1111);
    set_w(1, 5'd7, 32'h2222);
    set_ra(0, 5'd7);
    tick();
    chk("conflict_r7", rdp(0), 32'h2222);

    // r0 stays zero and never busy
    set_w(0, 5'd0, 32'hFFFFFFFF);
    set_c(0, 5'd0);
    tick();
    for (int p = 0; p < NR; p++) set_ra(p, 5'd0);
    #1;
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("r0_rd_p%0d", p), rdp(p), 32'h0);
      chk($sformatf("r0_busy_p%0d", p), {31'h0, rbusy[p]}, 32'h0);
    end

    // scoreboard priority
    set_ra(0, 5'd3);
    set_c(0, 5'd3);
    tick();
    chk("sb_claim3", {31'h0, rbusy[0]}, 32'h1);
    set_w(0, 5'd3, 32'h42);
    set_c(1, 5'd3);
    tick();
    chk("sb_reclaim3", {31'h0, rbusy[0]}, 32'h1);
    chk("sb_rd3", rdp(0), 32'h42);
    set_w(1, 5'd3, 32'h43);
    tick();
    chk("sb_clear3", {31'h0, rbusy[0]}, 32'h0);
    chk("sb_rd3b", rdp(0), 32'h43);

    // flush
    set_c(0, 5'd4);
    set_c(1, 5'd9);
    set_ra(1, 5'd4);
    set_ra(2, 5'd9);
    set_ra(3, 5'd10);
    tick();
    chk("fl_pre4", {31'h0, rbusy[1]}, 32'h1);
    chk("fl_pre9", {31'h0, rbusy[2]}, 32'h1);
    flush = 1'b1;
    set_c(0, 5'd10);
    tick();
    chk("fl_busy", {29'h0, rbusy[3:1]}, 32'h0);

    // write + flush: data still commits
    set_ra(0, 5'd20);
    set_c(0, 5'd20);
    tick();
    chk("wf_pre20", {31'h0, rbusy[0]}, 32'h1);
    set_w(1, 5'd20, 32'h77);
    flush = 1'b1;
    tick();
    chk("wf_rd20", rdp(0), 32'h77);
    chk("wf_busy20", {31'h0, rbusy[0]}, 32'h0);

    // same-cycle read of a write
    set_w(0, 5'd12, 32'h1234);
    set_c(0, 5'd12);
    tick();
    set_ra(0, 5'd12);
    set_w(0, 5'd12, 32'hCAFE);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd12", rdp(0), 32'hCAFE);
    chk("byp_busy12", {31'h0, rbusy[0]}, 32'h0);
`else
    chk("nobyp_rd12", rdp(0), 32'h1234);
    chk("nobyp_busy12", {31'h0, rbusy[0]}, 32'h1);
`endif
    tick();
    chk("byp_next12", rdp(0), 32'hCAFE);
    chk("byp_nbusy12", {31'h0, rbusy[0]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
